// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, followed by one sign fix-up cycle. The result is held until writeback acks.
module muldiv_unit #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 op_div,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
    input  logic [TAG_WIDTH-1:0] dest_in,
    input  logic                 flush,
    input  logic                 result_ack,
    output logic                 ready,
    output logic                 busy,
    output logic                 result_valid,
    output logic [WIDTH-1:0]     result,
    output logic [TAG_WIDTH-1:0] dest_out,
    output logic                 exception
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic                 accept;
    logic                 iter_en;
    logic                 finish;
    logic [CNT_W-1:0]     counter;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 op_div_q;
    logic                 neg_q;
    logic                 div_ovf_q;
    logic [WIDTH-1:0]     result_q;
    logic [TAG_WIDTH-1:0] dest_q;
    logic                 exception_q;

    logic [WIDTH-1:0]     mag_a_in;
    logic [WIDTH-1:0]     mag_b_in;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_sub;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_signed;
    logic [WIDTH-1:0]     quot_signed;
    logic [WIDTH-1:0]     fix_result;
    logic                 fix_exception;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // RUN spends WIDTH cycles iterating and one more (counter == WIDTH) on sign fix-up.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        iter_en    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (counter == LAST_COUNT) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end else begin
                    iter_en = 1'b1;
                end
            end
            DONE: begin
                if (result_ack || flush) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mag_a_in = operand_a[WIDTH-1] ? (~operand_a + 1'b1) : operand_a;
        mag_b_in = operand_b[WIDTH-1] ? (~operand_b + 1'b1) : operand_b;
    end

    // Multiply: low half starts as |b|; each step conditionally adds |a| to the high half and shifts right.
    always_comb begin
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_a} : '0);
        mul_next = {mul_sum, prod[WIDTH-1:1]};
    end

    // Divide: high half is the partial remainder, low half shifts the dividend out and quotient bits in.
    always_comb begin
        div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mag_b});
        div_sub   = div_shift - {1'b0, mag_b};
        div_next  = {(div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     prod[WIDTH-2:0], div_ge};
    end

    always_comb begin
        prod_signed   = neg_q ? (~prod + 1'b1) : prod;
        quot_signed   = neg_q ? (~prod[WIDTH-1:0] + 1'b1) : prod[WIDTH-1:0];
        fix_result    = '0;
        fix_exception = 1'b0;
        if (!op_div_q) begin
            fix_result    = prod_signed[WIDTH-1:0];
            fix_exception = (prod_signed[2*WIDTH-1:WIDTH] != {WIDTH{prod_signed[WIDTH-1]}});
        end else if (mag_b == '0) begin
            fix_result    = '0;
            fix_exception = 1'b1;
        end else if (div_ovf_q) begin
            fix_result    = MOST_NEG;
            fix_exception = 1'b1;
        end else begin
            fix_result    = quot_signed;
            fix_exception = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            counter     <= '0;
            prod        <= '0;
            mag_a       <= '0;
            mag_b       <= '0;
            op_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            div_ovf_q   <= 1'b0;
            result_q    <= '0;
            dest_q      <= '0;
            exception_q <= 1'b0;
        end else begin
            if (accept) begin
                counter   <= '0;
                mag_a     <= mag_a_in;
                mag_b     <= mag_b_in;
                op_div_q  <= op_div;
                neg_q     <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                div_ovf_q <= (operand_a == MOST_NEG) && (operand_b == {WIDTH{1'b1}});
                dest_q    <= dest_in;
                prod      <= {{WIDTH{1'b0}}, (op_div ? mag_a_in : mag_b_in)};
            end
            if (iter_en) begin
                counter <= counter + 1'b1;
                prod    <= op_div_q ? div_next : mul_next;
            end
            if (finish) begin
                result_q    <= fix_result;
                exception_q <= fix_exception;
            end
        end
    end

    assign ready        = (state == IDLE);
    assign busy         = ~ready;
    assign result_valid = (state == DONE);
    assign result       = result_q;
    assign dest_out     = dest_q;
    assign exception    = exception_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int W  = 32;
    localparam int TW = 5;
    localparam logic [W-1:0] MOST_NEG = 32'h8000_0000;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          op_div;
    logic [W-1:0]  operand_a;
    logic [W-1:0]  operand_b;
    logic [TW-1:0] dest_in;
    logic          flush;
    logic          result_ack;
    logic          ready;
    logic          busy;
    logic          result_valid;
    logic [W-1:0]  result;
    logic [TW-1:0] dest_out;
    logic          exception;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(W), .TAG_WIDTH(TW)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op_div      (op_div),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .dest_in     (dest_in),
        .flush       (flush),
        .result_ack  (result_ack),
        .ready       (ready),
        .busy        (busy),
        .result_valid(result_valid),
        .result      (result),
        .dest_out    (dest_out),
        .exception   (exception)
    );

    always #5 clock = ~clock;

    // Reference behaviour straight from the arithmetic rules, using 64-bit signed math.
    function automatic void refModel(input logic div, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] r, output logic e);
        longint p;
        int     qa;
        int     qb;
        if (!div) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[W-1:0];
            e = (p != longint'($signed(r)));
        end else if (b == '0) begin
            r = '0;
            e = 1'b1;
        end else if (a == MOST_NEG && b == 32'hFFFF_FFFF) begin
            r = MOST_NEG;
            e = 1'b1;
        end else begin
            qa = $signed(a);
            qb = $signed(b);
            r  = 32'(qa / qb);
            e  = 1'b0;
        end
    endfunction

    function automatic logic [W-1:0] pickOperand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = MOST_NEG;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(0, 20)) - 32'd10;
            default: v = 32'($urandom);
        endcase
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // Drives one start pulse; the tick inside is the accepting edge when ready is high.
    task automatic applyStimulus(input logic div, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [TW-1:0] tag);
        op_div    = div;
        operand_a = a;
        operand_b = b;
        dest_in   = tag;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        op_div    = 1'($urandom);
        operand_a = 32'($urandom);
        operand_b = 32'($urandom);
        dest_in   = TW'($urandom);
    endtask

    task automatic runOp(input string name, input logic div, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TW-1:0] tag, input int holdCycles);
        logic [W-1:0] expResult;
        logic         expExc;
        int           latency;
        refModel(div, a, b, expResult, expExc);
        applyStimulus(div, a, b, tag);
        latency = 0;
        for (int i = 1; i <= W + 8; i++) begin
            tick();
            if (result_valid === 1'b1) begin
                latency = i;
                break;
            end
        end
        checkOutput({name, ".latency"}, 64'(latency), 64'(W + 1));
        checkOutput({name, ".result"}, 64'(result), 64'(expResult));
        checkOutput({name, ".exception"}, 64'(exception), 64'(expExc));
        checkOutput({name, ".dest"}, 64'(dest_out), 64'(tag));
        checkOutput({name, ".busy"}, 64'(busy), 64'(1));
        for (int i = 0; i < holdCycles; i++) begin
            tick();
            checkOutput({name, ".holdValid"}, 64'(result_valid), 64'(1));
            checkOutput({name, ".holdResult"}, 64'(result), 64'(expResult));
            checkOutput({name, ".holdExc"}, 64'(exception), 64'(expExc));
        end
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        checkOutput({name, ".readyAfterAck"}, 64'(ready), 64'(1));
        checkOutput({name, ".validAfterAck"}, 64'(result_valid), 64'(0));
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, ".ready"}, 64'(ready), 64'(1));
        checkOutput({name, ".busy"}, 64'(busy), 64'(0));
        checkOutput({name, ".valid"}, 64'(result_valid), 64'(0));
        checkOutput({name, ".result"}, 64'(result), 64'(0));
        checkOutput({name, ".dest"}, 64'(dest_out), 64'(0));
        checkOutput({name, ".exception"}, 64'(exception), 64'(0));
    endtask

    initial begin
        logic sawValid;
        reset      = 1'b1;
        start      = 1'b0;
        op_div     = 1'b0;
        operand_a  = '0;
        operand_b  = '0;
        dest_in    = '0;
        flush      = 1'b0;
        result_ack = 1'b0;
        tick();
        tick();
        checkResetValues("reset");
        reset = 1'b0;
        tick();

        runOp("mul7xm3", 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd9, 0);
        runOp("mulOvf", 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd3, 0);
        runOp("mulMinx1", 1'b0, MOST_NEG, 32'd1, 5'd17, 0);
        runOp("divM7by2", 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd31, 0);
        runOp("divMinByM1", 1'b1, MOST_NEG, 32'hFFFF_FFFF, 5'd1, 0);
        runOp("div5by0", 1'b1, 32'd5, 32'd0, 5'd22, 5);

        // Second start mid-run is ignored; flush at edge 10 kills the operation.
        applyStimulus(1'b0, 32'd1234, 32'd5678, 5'd4);
        for (int i = 1; i <= 3; i++) tick();
        applyStimulus(1'b1, 32'd99, 32'd3, 5'd8);
        checkOutput("ignoredStart.busy", 64'(busy), 64'(1));
        for (int i = 5; i <= 9; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flushRun.ready", 64'(ready), 64'(1));
        checkOutput("flushRun.valid", 64'(result_valid), 64'(0));
        sawValid = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            if (result_valid !== 1'b0) sawValid = 1'b1;
        end
        checkOutput("flushRun.neverValid", 64'(sawValid), 64'(0));
        runOp("mul2x3", 1'b0, 32'd2, 32'd3, 5'd6, 0);

        // Flush competes with start in IDLE and wins.
        op_div = 1'b0;
        start  = 1'b1;
        flush  = 1'b1;
        tick();
        start  = 1'b0;
        flush  = 1'b0;
        checkOutput("flushStartIdle.ready", 64'(ready), 64'(1));

        // Flush of a held result drops it without an ack.
        applyStimulus(1'b0, 32'd10, 32'd10, 5'd2);
        for (int i = 1; i <= W + 1; i++) tick();
        checkOutput("flushDone.validBefore", 64'(result_valid), 64'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flushDone.valid", 64'(result_valid), 64'(0));
        checkOutput("flushDone.ready", 64'(ready), 64'(1));

        // Reset in the middle of a divide.
        applyStimulus(1'b1, 32'd1000, 32'd3, 5'd13);
        for (int i = 1; i <= 14; i++) tick();
        reset = 1'b1;
        tick();
        checkResetValues("midReset");
        reset = 1'b0;
        tick();
        runOp("div100by7", 1'b1, 32'd100, 32'd7, 5'd14, 0);

        for (int n = 0; n < 20; n++) begin
            runOp($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), pickOperand(), pickOperand(),
                  TW'($urandom), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
